// File: rtl/fmt_pkt_receiver.sv
// Single-packet receiver for the MCDF formatter interface: grants one packet,
// buffers it, checks its length and replays it as header + data on a valid/ready stream.
module fmt_pkt_receiver #(
  parameter int unsigned MAX_LEN   = 32,
  parameter int unsigned GRANT_DLY = 0,
  parameter int unsigned START_TO  = 16
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        fmt_req_i,
  output logic        fmt_grant_o,
  input  logic [1:0]  fmt_chid_i,
  input  logic [5:0]  fmt_length_i,
  input  logic [31:0] fmt_data_i,
  input  logic        fmt_start_i,
  input  logic        fmt_end_i,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic [31:0] rx_data_o,
  output logic        rx_sop_o,
  output logic        rx_eop_o,
  output logic        busy_o,
  output logic [7:0]  err_cnt_o
);

  localparam int unsigned CW = $clog2(MAX_LEN + 1);
  localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned DW = $clog2(GRANT_DLY + 2);
  localparam int unsigned TW = $clog2(START_TO + 1);

  typedef enum logic [2:0] {S_IDLE, S_GDLY, S_GRANT, S_WAIT, S_RECV, S_DRAIN} state_e;

  state_e          state_q, state_d;
  logic            grant_q, grant_d;
  logic            busy_q, busy_d;
  logic [1:0]      chid_q, chid_d;
  logic [5:0]      len_q, len_d;
  logic [DW-1:0]   dly_q, dly_d;
  logic [TW-1:0]   to_q, to_d;
  logic [CW-1:0]   wcnt_q, wcnt_d;
  logic [CW-1:0]   rd_q, rd_d;
  logic            err_q, err_d;
  logic            rx_valid_q, rx_valid_d;
  logic [31:0]     rx_data_q, rx_data_d;
  logic            rx_sop_q, rx_sop_d;
  logic            rx_eop_q, rx_eop_d;
  logic [7:0]      err_cnt_q, err_cnt_d;

  logic [31:0]     mem_q [MAX_LEN];
  logic            we_c;
  logic [AW-1:0]   waddr_c;
  logic            fin_c;
  logic [CW-1:0]   fin_cnt_c;
  logic            err_acc_c;
  logic            err_fin_c;
  logic            err_inc_c;
  logic [CW-1:0]   cnt_inc_c;
  logic            len_bad_c;

  assign cnt_inc_c = (wcnt_q < CW'(MAX_LEN)) ? wcnt_q + CW'(1) : wcnt_q;
  assign len_bad_c = (len_q == 6'd0) || (32'(len_q) > MAX_LEN);

  // Next-state and output computation
  always_comb begin
    state_d    = state_q;
    chid_d     = chid_q;
    len_d      = len_q;
    dly_d      = dly_q;
    to_d       = to_q;
    wcnt_d     = wcnt_q;
    rd_d       = rd_q;
    err_d      = err_q;
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    rx_sop_d   = rx_sop_q;
    rx_eop_d   = rx_eop_q;
    err_cnt_d  = err_cnt_q;
    we_c       = 1'b0;
    waddr_c    = AW'(wcnt_q);
    fin_c      = 1'b0;
    fin_cnt_c  = wcnt_q;
    err_acc_c  = err_q;
    err_fin_c  = 1'b0;
    err_inc_c  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (fmt_req_i) begin
          chid_d  = fmt_chid_i;
          len_d   = fmt_length_i;
          wcnt_d  = '0;
          rd_d    = '0;
          err_d   = 1'b0;
          dly_d   = '0;
          to_d    = '0;
          state_d = (GRANT_DLY > 0) ? S_GDLY : S_GRANT;
        end
      end
      S_GDLY: begin
        if (!fmt_req_i) begin
          state_d = S_IDLE;
        end else if (dly_q == DW'(GRANT_DLY - 1)) begin
          state_d = S_GRANT;
        end else begin
          dly_d = dly_q + DW'(1);
        end
      end
      S_GRANT: state_d = S_WAIT;
      S_WAIT: begin
        if (fmt_start_i) begin
          we_c    = 1'b1;
          waddr_c = '0;
          wcnt_d  = CW'(1);
          if (fmt_end_i) begin
            fin_c     = 1'b1;
            fin_cnt_c = CW'(1);
          end else begin
            state_d = S_RECV;
          end
        end else if (to_q == TW'(START_TO - 1)) begin
          state_d   = S_IDLE;
          err_inc_c = 1'b1;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      S_RECV: begin
        // Words past the buffer depth are dropped but still flag the packet
        we_c      = (wcnt_q < CW'(MAX_LEN));
        wcnt_d    = cnt_inc_c;
        err_acc_c = err_q | ~we_c | fmt_start_i;
        err_d     = err_acc_c;
        if (fmt_end_i) begin
          fin_c     = 1'b1;
          fin_cnt_c = cnt_inc_c;
        end
      end
      S_DRAIN: begin
        if (rx_valid_q && rx_ready_i) begin
          if (rx_eop_q) begin
            rx_valid_d = 1'b0;
            rx_sop_d   = 1'b0;
            rx_eop_d   = 1'b0;
            state_d    = S_IDLE;
          end else begin
            rx_data_d = mem_q[AW'(rd_q)];
            rx_sop_d  = 1'b0;
            rx_eop_d  = (rd_q == wcnt_q - CW'(1));
            rd_d      = rd_q + CW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Packet complete: judge it and load the header so it is valid next cycle
    if (fin_c) begin
      err_fin_c  = err_acc_c | (32'(fin_cnt_c) != 32'(len_q)) | len_bad_c;
      err_d      = err_fin_c;
      err_inc_c  = err_fin_c;
      state_d    = S_DRAIN;
      rx_valid_d = 1'b1;
      rx_sop_d   = 1'b1;
      rx_eop_d   = 1'b0;
      rx_data_d  = {8'hA5, 6'b0, chid_q, 2'b0, len_q, 7'b0, err_fin_c};
      rd_d       = '0;
    end

    if (err_inc_c && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end

    grant_d = (state_d == S_GRANT);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= S_IDLE;
      grant_q    <= 1'b0;
      busy_q     <= 1'b0;
      chid_q     <= '0;
      len_q      <= '0;
      dly_q      <= '0;
      to_q       <= '0;
      wcnt_q     <= '0;
      rd_q       <= '0;
      err_q      <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      rx_sop_q   <= 1'b0;
      rx_eop_q   <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
      chid_q     <= chid_d;
      len_q      <= len_d;
      dly_q      <= dly_d;
      to_q       <= to_d;
      wcnt_q     <= wcnt_d;
      rd_q       <= rd_d;
      err_q      <= err_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      rx_sop_q   <= rx_sop_d;
      rx_eop_q   <= rx_eop_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Packet storage; contents are only meaningful below the write count
  always_ff @(posedge clk_i) begin
    if (we_c) begin
      mem_q[waddr_c] <= fmt_data_i;
    end
  end

  assign fmt_grant_o = grant_q;
  assign busy_o      = busy_q;
  assign rx_valid_o  = rx_valid_q;
  assign rx_data_o   = rx_data_q;
  assign rx_sop_o    = rx_sop_q;
  assign rx_eop_o    = rx_eop_q;
  assign err_cnt_o   = err_cnt_q;

endmodule
